sc_clkdiv: RTL and testbench
============================

SC_CLKDIV -- requirements
Module: sc_clkdiv

Interface
REQ-001 SHALL have parameter DIV_W, default 8, meaning width of the divide-ratio and high-time fields.
REQ-002 SHALL have parameter MIN_HI, default 1, meaning minimum high time of clk_out in clk cycles, guaranteeing the downstream non-overlap generator a pulse wider than its non-overlap time.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rstn, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port en, input, 1 bit: run enable.
REQ-006 SHALL have port start, input, 1 bit: start request, sampled on the rising clk edge.
REQ-007 SHALL have port div_ratio, input, DIV_W bits: output period N in clk cycles.
REQ-008 SHALL have port hi_cnt, input, DIV_W bits: requested high time in clk cycles.
REQ-009 SHALL have port burst_len, input, 16 bits: number of periods to emit; 0 means continuous.
REQ-010 SHALL have port clk_out, output, 1 bit, registered: divided clock that feeds the two-phase generator.
REQ-011 SHALL have port busy, output, 1 bit: high when state is not IDLE.
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse when a burst completes or a stop completes.
REQ-013 SHALL have port phase_cnt, output, DIV_W bits: current in-period cycle count.

Function
REQ-014 SHALL implement states IDLE, RUN and STOP.
REQ-015 In IDLE, an edge with start=1 and en=1 SHALL cause the following updates at that edge: state to RUN, phase_cnt to 0, period counter to 0, clk_out to 1, and latching of N_eff and HI_eff.
REQ-016 N_eff SHALL be max(div_ratio, 2); a div_ratio of 0 or 1 is treated as 2.
REQ-017 HI_eff SHALL be min(max(hi_cnt, MIN_HI), N_eff-1), so that clk_out always has at least 1 low cycle and at least MIN_HI high cycles.
REQ-018 In RUN, phase_cnt SHALL increment each edge; when phase_cnt==N_eff-1 it SHALL wrap to 0 and the period counter SHALL increment.
REQ-019 At each wrap, N_eff and HI_eff SHALL be re-latched from the current inputs; mid-period input changes SHALL have no effect.
REQ-020 clk_out SHALL be registered as (next phase_cnt < HI_eff): it is high for exactly HI_eff cycles and low for N_eff-HI_eff cycles of each period.
REQ-021 When burst_len≠0 and the period counter reaches burst_len at a wrap, the block SHALL go to IDLE with clk_out=0, and done SHALL pulse for 1 cycle.
REQ-022 en=0 sampled in RUN SHALL cause a transition to STOP.
REQ-023 STOP SHALL finish the current period unchanged: the falling edge of clk_out occurs at its normal point, with no truncated high pulse.
REQ-024 STOP SHALL go to IDLE at the next wrap with done=1 for 1 cycle; no new high pulse begins.
REQ-025 start while busy=1 SHALL be ignored.
REQ-026 en re-asserted while in STOP SHALL NOT resume; the current period completes and a new start is required.
REQ-027 A burst end and an en=0 on the same wrap edge SHALL produce IDLE with one done pulse.
REQ-028 Every period boundary SHALL produce exactly one rising edge of clk_out; glitches and runt pulses are forbidden under all input changes.
REQ-029 The period counter SHALL be 16 bits; in continuous mode it SHALL saturate and never terminate the run.

Reset
REQ-030 rstn=0 SHALL asynchronously force: state to IDLE, clk_out=0, busy=0, done=0, phase_cnt=0, period counter=0, N_eff=2, HI_eff=1.
REQ-031 Reset asserted mid-period SHALL drop clk_out to 0 immediately; the resulting truncated pulse is accepted as the system-reset case.
REQ-032 After rstn deassertion, the block SHALL remain in IDLE until a start sampled with en=1.

Verification
REQ-033 The bench SHALL cover: div_ratio=5, hi_cnt=2, burst_len=3, start -> three periods of 2 high / 3 low cycles, then done pulse at the 15th cycle edge, busy=0, clk_out=0.
REQ-034 The bench SHALL cover: div_ratio=1, hi_cnt=0, continuous -> N_eff=2, HI_eff=1, so clk_out toggles every cycle indefinitely.
REQ-035 The bench SHALL cover: div_ratio=8, hi_cnt=4, en dropped at phase_cnt=1 -> clk_out stays high through phase_cnt 3, low 4..7, then IDLE with done at the wrap and no further high pulse.
REQ-036 The bench SHALL cover: div_ratio changed from 4 to 6 at phase_cnt=2 -> the current period remains 4 cycles and the next period is 6.
REQ-037 The bench SHALL cover: hi_cnt=9 with div_ratio=6 -> HI_eff=5, giving 5 high / 1 low cycles.
REQ-038 The bench SHALL cover: rstn pulsed low mid-high-phase -> clk_out=0 and busy=0 asynchronously; start after release restarts cleanly from phase_cnt=0.

Source files
------------

// File: rtl/sc_clkdiv.sv
// Programmable clock divider with burst/continuous modes and a clean stop that
// always completes the current period, so clk_out never carries a runt pulse.
module sc_clkdiv #(
    parameter int DIV_W  = 8,
    parameter int MIN_HI = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             start,
    input  logic [DIV_W-1:0] div_ratio,
    input  logic [DIV_W-1:0] hi_cnt,
    input  logic [15:0]      burst_len,
    output logic             clk_out,
    output logic             busy,
    output logic             done,
    output logic [DIV_W-1:0] phase_cnt
);

    typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

    localparam logic [DIV_W-1:0] TWO    = DIV_W'(2);
    localparam logic [DIV_W-1:0] ONE    = DIV_W'(1);
    localparam logic [DIV_W-1:0] MIN_HV = DIV_W'(MIN_HI);

    state_t           state_q;
    logic [DIV_W-1:0] phase_q, n_q, hi_q;
    logic [15:0]      per_q;
    logic             clk_q, busy_q, done_q;

    logic [DIV_W-1:0] n_d, hmax, hi_d, phase_nxt;
    logic [15:0]      per_inc;
    logic             wrap, burst_end;

    // Effective ratio/high time as they would be latched at this edge.
    always_comb begin
        n_d       = (div_ratio < TWO) ? TWO : div_ratio;
        hmax      = (hi_cnt < MIN_HV) ? MIN_HV : hi_cnt;
        hi_d      = (hmax > n_d - ONE) ? n_d - ONE : hmax;
        phase_nxt = phase_q + ONE;
        wrap      = (phase_q == n_q - ONE);
        per_inc   = (per_q == 16'hFFFF) ? per_q : per_q + 16'd1;
        burst_end = (burst_len != 16'd0) && (per_inc >= burst_len);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            phase_q <= '0;
            per_q   <= '0;
            n_q     <= TWO;
            hi_q    <= ONE;
            clk_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start && en) begin
                        state_q <= RUN;
                        phase_q <= '0;
                        per_q   <= '0;
                        n_q     <= n_d;
                        hi_q    <= hi_d;
                        clk_q   <= (hi_d != '0);
                        busy_q  <= 1'b1;
                    end
                end
                RUN, STOP: begin
                    if (wrap) begin
                        per_q   <= per_inc;
                        phase_q <= '0;
                        // A stop or disable seen on the wrap edge ends cleanly
                        // here rather than opening a period it would cut short.
                        if (state_q == STOP || !en || burst_end) begin
                            state_q <= IDLE;
                            clk_q   <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            n_q   <= n_d;
                            hi_q  <= hi_d;
                            clk_q <= (hi_d != '0);
                        end
                    end else begin
                        phase_q <= phase_nxt;
                        clk_q   <= (phase_nxt < hi_q);
                        if (state_q == RUN && !en) state_q <= STOP;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign clk_out   = clk_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign phase_cnt = phase_q;

endmodule

// File: tb/tb_sc_clkdiv.sv
// Self-checking bench for sc_clkdiv: directed scenarios with literal
// expectations plus randomized stimulus against a period-level model.
module tb_sc_clkdiv;

    localparam int DIV_W = 8;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             en = 1'b0;
    logic             start = 1'b0;
    logic [DIV_W-1:0] div_ratio = '0;
    logic [DIV_W-1:0] hi_cnt = '0;
    logic [15:0]      burst_len = '0;
    logic             clk_out, busy, done;
    logic [DIV_W-1:0] phase_cnt;

    int checks = 0;
    int failures = 0;

    sc_clkdiv #(.DIV_W(DIV_W), .MIN_HI(1)) dut (
        .clk(clk), .rstn(rstn), .en(en), .start(start),
        .div_ratio(div_ratio), .hi_cnt(hi_cnt), .burst_len(burst_len),
        .clk_out(clk_out), .busy(busy), .done(done), .phase_cnt(phase_cnt)
    );

    always #5 clk = ~clk;

    // Model: a run is a sequence of periods of length N; position pos within
    // the period; output is high while pos < HI.
    bit m_active, m_stopping, m_done;
    int m_pos, m_per, m_N, m_HI;

    function automatic int neff(int d);
        return (d < 2) ? 2 : d;
    endfunction

    function automatic int hieff(int h, int n);
        int x;
        x = (h < 1) ? 1 : h;
        return (x > n - 1) ? n - 1 : x;
    endfunction

    task automatic model_step();
        m_done = 1'b0;
        if (!rstn) begin
            m_active = 0; m_stopping = 0; m_pos = 0; m_per = 0; m_N = 2; m_HI = 1;
        end else if (!m_active) begin
            if (start && en) begin
                m_active = 1; m_stopping = 0; m_pos = 0; m_per = 0;
                m_N = neff(int'(div_ratio));
                m_HI = hieff(int'(hi_cnt), m_N);
            end
        end else if (m_pos == m_N - 1) begin
            m_per = (m_per < 65535) ? m_per + 1 : 65535;
            m_pos = 0;
            if (m_stopping || !en || (burst_len != 0 && m_per >= int'(burst_len))) begin
                m_active = 0; m_done = 1;
            end else begin
                m_N = neff(int'(div_ratio));
                m_HI = hieff(int'(hi_cnt), m_N);
            end
        end else begin
            m_pos++;
            if (!en) m_stopping = 1;
        end
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_loop();
        logic [31:0] act, exp;
        forever begin
            @(posedge clk);
            model_step();
            #2;
            act = {21'd0, clk_out, busy, done, phase_cnt};
            exp = {21'd0, (m_active && m_pos < m_HI), m_active, m_done, 8'(m_pos)};
            chk("model{clk_out,busy,done,phase}", act, exp);
        end
    endtask

    task automatic wait_idle(string name);
        int n;
        n = 0;
        while (busy && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_idle_timeout"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic go(int d, int h, int b);
        @(negedge clk);
        div_ratio = 8'(d); hi_cnt = 8'(h); burst_len = 16'(b);
        en = 1; start = 1;
        @(negedge clk);
        start = 0;
    endtask

    logic [15:0] pat;
    int          ph[10];
    int          exp_ph[10] = '{0, 1, 2, 3, 0, 1, 2, 3, 4, 5};
    int          n;

    initial begin
        fork
            compare_loop();
        join_none

        repeat (3) @(negedge clk);
        chk("reset_outputs", {28'd0, clk_out, busy, done, 1'b0} | {24'd0, phase_cnt}, 32'd0);
        rstn = 1;
        @(negedge clk);

        // 5 / 2 / burst 3: three periods 11000, done after the 15th edge
        go(5, 2, 3);
        pat = '0;
        pat[0] = clk_out;
        for (int i = 1; i < 15; i++) begin
            @(negedge clk);
            pat[i] = clk_out;
        end
        chk("burst_pattern", {17'd0, pat[14:0]}, 32'b110001100011);
        @(negedge clk);
        chk("burst_done", {29'd0, done, busy, clk_out}, 32'b100);
        @(negedge clk);
        chk("burst_done_one_cycle", {31'd0, done}, 32'd0);

        // ratio 1, hi 0, continuous: toggles every cycle
        go(1, 0, 0);
        pat = '0;
        pat[0] = clk_out;
        for (int i = 1; i < 8; i++) begin
            @(negedge clk);
            pat[i] = clk_out;
        end
        chk("div1_toggle", {24'd0, pat[7:0]}, 32'h55);
        en = 0;
        wait_idle("div1");

        // 8 / 4, en dropped at phase 1: high through 3, low 4..7, then done
        go(8, 4, 0);
        n = 0;
        while (phase_cnt != 1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("stop_reach_phase1", {24'd0, phase_cnt}, 32'd1);
        en = 0;
        pat = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            pat[i] = clk_out;
        end
        chk("stop_pattern", {26'd0, pat[5:0]}, 32'b000011);
        @(negedge clk);
        chk("stop_done", {29'd0, done, busy, clk_out}, 32'b100);
        en = 1;
        pat = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            pat[i] = clk_out | busy;
        end
        chk("stop_no_restart", {28'd0, pat[3:0]}, 32'd0);

        // ratio 4 -> 6 mid-period: current stays 4, next is 6
        go(4, 2, 0);
        ph[0] = int'(phase_cnt);
        for (int i = 1; i < 10; i++) begin
            if (i == 3) div_ratio = 8'd6;
            @(negedge clk);
            ph[i] = int'(phase_cnt);
        end
        for (int i = 0; i < 10; i++) chk("ratio_change_phase", 32'(ph[i]), 32'(exp_ph[i]));
        en = 0;
        wait_idle("ratio_change");

        // hi 9, ratio 6 -> 5 high / 1 low, burst 2
        go(6, 9, 2);
        pat = '0;
        pat[0] = clk_out;
        for (int i = 1; i < 12; i++) begin
            @(negedge clk);
            pat[i] = clk_out;
        end
        chk("hi_clamp_pattern", {20'd0, pat[11:0]}, 32'b011111011111);
        @(negedge clk);
        chk("hi_clamp_done", {29'd0, done, busy, clk_out}, 32'b100);

        // async reset mid-high-phase
        go(8, 4, 0);
        @(negedge clk);
        chk("rst_pre_high", {31'd0, clk_out}, 32'd1);
        #2 rstn = 0;
        #1 chk("rst_async", {23'd0, clk_out, busy, phase_cnt}, 32'd0);
        @(negedge clk);
        rstn = 1;
        @(negedge clk);
        chk("rst_stays_idle", {30'd0, busy, clk_out}, 32'd0);
        go(8, 4, 0);
        chk("rst_restart", {22'd0, busy, clk_out, phase_cnt}, 32'h300);
        repeat (4) @(negedge clk);
        chk("rst_restart_p4", {23'd0, clk_out, phase_cnt}, 32'd4);
        en = 0;
        wait_idle("rst");

        // randomized: model compare runs every cycle
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            en = ($urandom % 25) != 0;
            start = ($urandom % 6) == 0;
            if ($urandom % 8 == 0) div_ratio = 8'($urandom_range(0, 12));
            if ($urandom % 8 == 0) hi_cnt = 8'($urandom_range(0, 14));
            if ($urandom % 40 == 0) burst_len = 16'($urandom_range(0, 5));
            rstn = ($urandom % 400) != 0;
        end
        @(negedge clk);
        rstn = 1; start = 0;
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
